// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while iterating and issues a single write-back pulse when the result is ready.
module div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            cancel_i,
  output logic            stall_o,
  output logic            ready_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, div_q;
  logic [XLEN-1:0]   res_q, result_q;
  logic [1:0]        op_q;
  logic [4:0]        waddr_q;
  logic              neg_quo_q, neg_rem_q;

  logic              accept, is_signed, div_zero, overflow;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   rem_nx, quo_nx, fixed_res;

  assign accept    = (state_q == IDLE) & start_i & ~cancel_i;
  assign is_signed = ~op_i[0];
  assign div_zero  = (divisor_i == '0);
  assign overflow  = is_signed & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (divisor_i == '1);
  assign abs_a     = (is_signed & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign abs_b     = (is_signed & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  // One restoring step: the shifted remainder needs XLEN+1 bits so the trial subtract's sign is exact
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, div_q};
    rem_nx = rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end
    if (op_q[1]) fixed_res = neg_rem_q ? -rem_nx : rem_nx;
    else         fixed_res = neg_quo_q ? -quo_nx : quo_nx;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall_o  = 1'b0;
    ready_o  = 1'b0;
    reg_we_o = 1'b0;
    result_o = result_q;
    case (state_q)
      IDLE: begin
        stall_o = accept;
        if (accept) state_d = (div_zero | overflow) ? DONE : CALC;
      end
      CALC: begin
        stall_o = 1'b1;
        if (cancel_i)         state_d = IDLE;
        else if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d  = IDLE;
        ready_o  = ~cancel_i;
        reg_we_o = ~cancel_i;
        if (!cancel_i) result_o = res_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result staging; result_q only moves on a completed write-back
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      res_q     <= '0;
      result_q  <= '0;
      op_q      <= '0;
      waddr_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= op_i;
          waddr_q   <= reg_waddr_i;
          neg_quo_q <= is_signed & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          neg_rem_q <= is_signed & dividend_i[XLEN-1];
          if (div_zero)      res_q <= op_i[1] ? dividend_i : '1;
          else if (overflow) res_q <= op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          else begin
            rem_q <= '0;
            quo_q <= abs_a;
            div_q <= abs_b;
            cnt_q <= CNT_W'(XLEN-1);
          end
        end
        CALC: if (!cancel_i) begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) res_q <= fixed_res;
        end
        DONE: if (!cancel_i) result_q <= res_q;
        default: ;
      endcase
    end
  end

  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, cancel/reset sequences and randomized ops vs a reference model.
module tb_div_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, cancel_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        stall_o, ready_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] result_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] last_result = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .cancel_i(cancel_i), .stall_o(stall_o), .ready_o(ready_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model straight from the RV32M rules using native integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one op for a single cycle, then follow it to its write-back pulse
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic stall_gap;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
    #1;
    checkOutput("stall_cycle0", 32'(stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = 5'(~rd);
    lat = 1;
    stall_gap = 1'b0;
    forever begin
      @(negedge clk_i);
      if (ready_o || lat > 40) break;
      if (!stall_o || reg_we_o) stall_gap = 1'b1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("stall_during_calc", 32'(stall_gap), 32'd0);
    checkOutput("stall_in_done", 32'(stall_o), 32'd0);
    checkOutput("reg_we", 32'(reg_we_o), 32'd1);
    checkOutput("result", result_o, exp);
    checkOutput("waddr", 32'(reg_waddr_o), 32'(rd));
    last_result = exp;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
    op_i = '0; dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;

    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          33});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15,         33});
    vecs.push_back('{2'b00, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  33});
    vecs.push_back('{2'b10, 32'd20,         32'hFFFF_FFFD,  32'd2,          33});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'd0,          32'h8000_0000,  1});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33});
    vecs.push_back('{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          33});

    #12;
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_ready", 32'(ready_o), 32'd0);
    checkOutput("reset_we", 32'(reg_we_o), 32'd0);
    checkOutput("reset_waddr", 32'(reg_waddr_o), 32'd0);
    checkOutput("reset_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Directed table, issued back-to-back straight out of each DONE
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat);

    @(negedge clk_i);
    checkOutput("ready_after_done", 32'(ready_o), 32'd0);
    checkOutput("result_hold", result_o, last_result);

    // start and cancel together in IDLE: nothing accepted
    start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd0;
    #1;
    checkOutput("start_cancel_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checkOutput("start_cancel_idle", {30'd0, stall_o, ready_o}, 32'd0);
    end

    // Cancel in DONE of a divide-by-zero op
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; dividend_i = 32'd77; divisor_i = 32'd0; reg_waddr_i = 5'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    cancel_i = 1'b1;
    #1;
    checkOutput("cancel_done_ready", 32'(ready_o), 32'd0);
    checkOutput("cancel_done_we", 32'(reg_we_o), 32'd0);
    checkOutput("cancel_done_result", result_o, last_result);
    @(posedge clk_i); #1;
    cancel_i = 1'b0;
    @(negedge clk_i);
    checkOutput("cancel_done_after", result_o, last_result);

    // DIVU 1000/3 cancelled in cycle 10
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd12;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    checkOutput("cancel_calc_stall", 32'(stall_o), 32'd1);
    cancel_i = 1'b1;
    @(posedge clk_i); #1;
    cancel_i = 1'b0;
    @(negedge clk_i);
    checkOutput("cancel_idle_stall", 32'(stall_o), 32'd0);
    begin
      logic pulse = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk_i);
        if (reg_we_o || ready_o) pulse = 1'b1;
      end
      checkOutput("cancel_no_pulse", 32'(pulse), 32'd0);
    end
    checkOutput("cancel_result_kept", result_o, last_result);
    applyStimulus(2'b01, 32'd9, 32'd3, 5'd13, 32'd3, 33);

    // Asynchronous reset in the middle of cycle 20 of DIVU 0xFFFFFFFF/1
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd1; reg_waddr_i = 5'd21;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    checkOutput("pre_reset_stall", 32'(stall_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("midreset_flags", {29'd0, stall_o, ready_o, reg_we_o}, 32'd0);
    checkOutput("midreset_waddr", 32'(reg_waddr_o), 32'd0);
    checkOutput("midreset_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    last_result = '0;
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd22, 32'hFFFF_FFFF, 33);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      applyStimulus(op, a, b, 5'($urandom), ref_div(op, a, b), ref_lat(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, in parallel with the single-cycle ALU inside the exe stage.
- Holds the pipeline through stall_o while a radix-2 restoring divide iterates.
- Issues one write-back request (reg_we_o, reg_waddr_o, result_o) toward exe_mem when the result is ready.
- Resolves divide-by-zero and signed overflow without iterating.

Parameters:
XLEN, 32, operand/result width (matches `RegBus)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  divide op present in exe stage (from id_exe decode)
op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend_i  in  XLEN  rs1 value
divisor_i  in  XLEN  rs2 value
reg_waddr_i  in  5  destination register (`RegAddrBus)
cancel_i  in  1  pipeline flush; abort current op
stall_o  out  1  hold pc/if_id/id_exe/exe
ready_o  out  1  result valid, one-cycle pulse
reg_we_o  out  1  write-back enable, equals ready_o
reg_waddr_o  out  5  latched destination register
result_o  out  XLEN  quotient or remainder

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - stall_o, ready_o and reg_we_o are 0.
  - reg_waddr_o and result_o are 0.
  - Internal registers are cleared.
- State IDLE:
  - start_i=1 and cancel_i=0 are sampled at the clock edge.
  - Latched at that edge: op, reg_waddr, dividend/divisor sign flags, and the absolute values (absolute only for DIV/REM).
  - divisor==0 goes to DONE with a precomputed result:
    - DIV/DIVU: 0xFFFFFFFF.
    - REM/REMU: the dividend, unmodified.
  - Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF) goes to DONE:
    - DIV: 0x80000000.
    - REM: 0.
  - Otherwise: counter=XLEN-1, remainder accumulator=0, go to CALC.
- State CALC, one quotient bit per cycle:
  - Shift {rem,quo} left 1.
  - Trial subtract rem-divisor over XLEN+1 bits.
  - If non-negative, keep the difference and set quo[0]=1.
  - Decrement the counter. The step taken with counter==0 is the last; go to DONE.
- State DONE, exactly one cycle:
  - ready_o=1 and reg_we_o=1; result_o and reg_waddr_o are valid.
  - Next state is IDLE.
- Sign fix-up, applied when entering DONE from CALC:
  - DIV: quotient negated (two's complement) when the dividend and divisor signs differ.
  - REM: remainder negated when the dividend was negative.
  - DIVU/REMU: no fix-up.
- result_o holds its value after DONE until the next DONE; ready_o and reg_we_o are 0 outside DONE.
- stall_o (combinational) = (state==CALC) | (state==IDLE & start_i & ~cancel_i).
  - The exe stage stalls in the same cycle the op arrives.
  - stall_o=0 in DONE, so the pipeline advances and exe_mem captures the result on that edge.
- start_i is ignored in CALC and DONE; in DONE it is still the same, now completing, instruction.
- Back-to-back divides: a new op is accepted in the IDLE cycle immediately after DONE.
- Latency, with the start edge as cycle 0:
  - Normal op: CALC occupies cycles 1..32, DONE is cycle 33.
  - Zero/overflow op: DONE is cycle 1.
- cancel_i:
  - In any state, the next state is IDLE.
  - No ready_o/reg_we_o pulse is produced; result_o keeps its previous value.
  - Cancel in DONE suppresses ready_o/reg_we_o that cycle.
  - start_i and cancel_i together in IDLE: cancel wins, stall_o=0, nothing is latched.
- Reset mid-operation: abort immediately with no write-back, and all reset values apply.

Test Plan:
- DIVU 100/7: stall_o high cycles 0..32, ready_o and reg_we_o pulse in cycle 33, result_o=14, reg_waddr_o equals the latched rd.
- REM 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
- DIV 5/0 -> DONE at cycle 1 with result_o=0xFFFFFFFF; REMU 5/0 -> result_o=5; stall_o high only in cycle 0.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM with the same operands -> 0.
- DIVU 1000/3 with cancel_i at cycle 10:
  - state is IDLE and stall_o=0 at cycle 11; no reg_we_o pulse;
  - a following DIVU 9/3 completes with result_o=3.
- DIVU 0xFFFFFFFF/1 with rst_i=0 at cycle 20 (asynchronous, mid-cycle):
  - all outputs are 0 immediately;
  - after release, a new op starts cleanly and gives the correct result.
